mux4_rr_arbiter: RTL
====================

// Module: mux4_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one 4:1 selection mux among four requesters.
//   It grants the mux to one requester at a time and drives the mux select code.
//   A grant is held until the owner drops its request or a hold timeout expires.
//   It sits directly in front of the 4:1 mux. sel feeds the mux select input, and
//   requester i's data drives mux data bit i.
// PARAMETERS
//   MAX_HOLD  8  maximum consecutive cycles one owner may hold the grant; legal range 1..255
// PORTS
//   clk      in   1  system clock; all state updates on the rising edge
//   rst_n    in   1  asynchronous, active-low reset
//   req      in   4  request per requester; bit i = requester i; level-sensitive
//   gnt      out  4  one-hot grant to the current owner; all zero when idle
//   sel      out  2  binary index of the owner, wired to the mux select input
//   busy     out  1  high while any grant is active (busy == |gnt)
//   timeout  out  1  one-cycle pulse when a grant is revoked by the MAX_HOLD expiry
// BEHAVIOUR
//   Clock and reset: single clock, clk. Reset is rst_n, asynchronous, active-low.
//   Reset values (applied immediately on rst_n low, regardless of clk):
//     - gnt=0, sel=0, busy=0, timeout=0
//     - state=IDLE, ptr=0, hold_cnt=0
//   Output timing: all outputs are registered; there are no combinational paths from req.
//   Priority pointer (ptr, 2b):
//     - the search starts at ptr and proceeds ptr, ptr+1, ... modulo 4
//     - when a grant is issued, ptr <= winner+1 (mod 4)
//   State IDLE:
//     - req==0: stay in IDLE. gnt=0, busy=0, and sel keeps its last value so the mux output stays stable.
//     - req!=0: pick the winner W by a search from ptr. On the next edge: gnt=1<<W, sel=W, busy=1,
//       hold_cnt=0, state=GRANT.
//     - Latency from req to gnt is exactly 1 cycle.
//   State GRANT (owner O):
//     - The grant is held while req[O]=1 and hold_cnt<MAX_HOLD-1. hold_cnt increments every cycle.
//     - Release condition R: req[O]=0, or hold_cnt==MAX_HOLD-1 with req[O]=1 (timeout).
//     - On R, re-arbitrate in the same cycle with search start O+1. O is therefore lowest priority
//       and can win only when it is the sole requester.
//     - R with a winner W found: next edge gnt=1<<W, sel=W, hold_cnt=0. There is no idle bubble, so
//       busy stays 1.
//     - R with no requester: next edge gnt=0, busy=0, state=IDLE, and sel holds O.
//     - timeout=1 for exactly the cycle after a timeout-caused release. This holds even when O is
//       re-granted to itself.
//     - Requests from non-owners during GRANT are ignored until R. They are not latched, so a
//       requester that drops its req before R is not served.
//   MAX_HOLD=1 limits every grant to one cycle, which gives per-cycle round-robin under full load.
//   hold_cnt width is 8 bits. It never exceeds MAX_HOLD-1, so no wrap can occur.
//   Invariants:
//     - gnt is always one-hot or zero
//     - sel==index(gnt) whenever busy=1
//     - timeout only ever pulses while busy=1 in the preceding cycle
//   Reset mid-grant: all state clears immediately. After reset the first arbitration starts from ptr=0.
// TESTING
//   1 Reset, then req=0001 -> one cycle later gnt=0001, sel=00, busy=1; drop req -> next cycle gnt=0, busy=0, sel=00.
//   2 MAX_HOLD=4, req=1111 held -> owners 0,1,2,3,0 for 4 cycles each; timeout pulses at each switch; gnt never 0.
//   3 Owner 1; req[1] falls in the same cycle req=0101 -> next cycle gnt=0100, sel=10, busy stays 1, no timeout.
//   4 MAX_HOLD=4, only req[3] held 10 cycles -> gnt=1000 throughout; timeout pulses after cycles 4 and 8.
//   5 Idle with ptr=1 (last owner 0), req=1001 -> gnt=1000, sel=11; then ptr=0, so the next contest favours 0.
//   6 rst_n low mid-grant (owner 2) -> gnt=0, busy=0 asynchronously; after release req=1010 -> gnt=0010.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving the select of a shared 4:1 mux
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  // Last hold_cnt value an owner may reach before its grant is revoked.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       timeout_q, timeout_d;

  logic [1:0] search_start;
  logic       win_found;
  logic [1:0] win_idx;
  logic       own_req;
  logic       expired;
  logic       release_now;

  // First requester found scanning start, start+1, ... modulo 4; {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // State register: all arbiter state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      hold_cnt_q <= 8'd0;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic: arbitration from ptr when idle, from owner+1 on release.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    timeout_d  = 1'b0;

    search_start = (state_q == IDLE) ? ptr_q : (sel_q + 2'd1);
    {win_found, win_idx} = rr_pick(req, search_start);
    own_req     = req[sel_q];
    expired     = (hold_cnt_q == HOLD_LAST);
    release_now = (state_q == GRANT) && (!own_req || expired);

    if (state_q == GRANT && !release_now) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end else if (state_q == IDLE || release_now) begin
      // Timeout flag only when the owner still wanted the mux.
      timeout_d = release_now && own_req;
      if (win_found) begin
        state_d    = GRANT;
        gnt_d      = 4'b0001 << win_idx;
        sel_d      = win_idx;
        ptr_d      = win_idx + 2'd1;
        hold_cnt_d = 8'd0;
      end else begin
        // sel keeps the old owner so the mux output stays stable while idle.
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    end
  end

  // Outputs come straight from flops; no combinational path from req.
  always_comb begin
    gnt     = gnt_q;
    sel     = sel_q;
    busy    = (state_q == GRANT);
    timeout = timeout_q;
  end

endmodule
